alu_unit: RTL and testbench
===========================

# alu_unit

16-bit arithmetic/logic/shift unit with a registered S/Z/C/V condition-flag register and branch-condition decode. It sits in the processor datapath between the operand registers (A = Rb path, B = Ra / immediate / input path) and the result register DR. Result and next-flags are combinational; only the flag register is clocked.

## Interface
Parameters: none (width fixed at 16).
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears flag register
- op  in  4  operation select (instruction bits [7:4] for class-11 instructions; 0000 for address/branch adds)
- data_a  in  16  operand A
- data_b  in  16  operand B; shift amount = data_b[3:0]
- flag_en  in  1  commit strobe: latch flag_out into flag register this edge if flag_write
- alu_out  out  16  combinational result
- flag_out  out  4  combinational next flags {V,C,Z,S} = bits [3:0] as S=0, Z=1, C=2, V=3
- flag_write  out  1  combinational: op updates flags
- flags_q  out  4  registered flags, same bit order
- cond_eq, cond_lt, cond_le, cond_ne  out  1 each  from flags_q: Z; S^V; Z|(S^V); !Z

## Operation
- Opcodes: ADD 0000 A+B; SUB 0001 A−B; AND 0010; OR 0011; XOR 0100; CMP 0101 (A−B, alu_out = difference, caller discards); MOV 0110 out=B; SLL 1000 A<<n; SLR 1001 rotate-left A by n; SRL 1010 logical right; SRA 1011 arithmetic right; IDT 1100 out=B; OUT 1101 out=A; HALT 1111 out=0; 0111, 1110 unused, out=0.
- n = data_b[3:0], 0..15; n=0 passes A unchanged.
- flag_write = 1 for ADD, SUB, AND, OR, XOR, CMP, MOV, SLL, SLR, SRL, SRA; 0 for IDT, OUT, HALT, unused.
- S = alu_out[15]; Z = (alu_out == 0) for all flag-writing ops.
- ADD: C = carry out of bit 15; V = signed overflow (A[15]==B[15] && out[15]!=A[15]).
- SUB/CMP: C = borrow (A < B unsigned); V = (A[15]!=B[15] && out[15]!=A[15]).
- Logic, MOV, SLR: C=0, V=0. SLL/SRL/SRA: C = last bit shifted out (0 when n=0), V=0.
- When flag_write=0, flag_out = 0.
- All arithmetic modulo 2^16; no saturation.

## Timing
- alu_out, flag_out, flag_write: purely combinational, zero latency.
- flags_q: updated on rising clock when flag_en=1 and flag_write=1; otherwise holds.
- flag_en=1 with non-flag op: no change.
- reset low: flags_q = 0 immediately (async), cond_eq=0, cond_lt=0, cond_le=0, cond_ne=1; release synchronous to next edge, no update on the release edge unless flag_en=1.
- cond_* follow flags_q combinationally (valid one cycle after commit).

## Configuration
- ALU_SHIFT_EN defined: SLL/SLR/SRL/SRA as above.
- Undefined: opcodes 1000–1011 treated as unused (alu_out=0, flag_write=0); shifter logic not instantiated.

## Structure
- Package alu_pkg: 4-bit opcode constants (OP_ADD … OP_HALT), flag bit indices (FLAG_S=0, FLAG_Z=1, FLAG_C=2, FLAG_V=3).
- One sub-module alu_shifter (data, n, op[1:0] → result, carry), instantiated under ALU_SHIFT_EN.
- Flag register and condition decode in alu_unit top.

## Test plan
- ADD 0x7FFF + 0x0001, flag_en=1 → alu_out 0x8000; flags_q after edge S=1 Z=0 C=0 V=1; cond_lt=0.
- SUB 0x0003 − 0x0005 → 0xFFFE, S=1 C=1 V=0; cond_lt=1, cond_le=1. CMP 0x1234 vs 0x1234 → Z=1, cond_eq=1, cond_ne=0.
- SLL 0x8001 n=1 → 0x0002 C=1; SRA 0x8000 n=15 → 0xFFFF; SLR 0x8001 n=4 → 0x0018; n=0 → passthrough, C=0.
- IDT/OUT/HALT with flag_en=1 → flag_write=0, flags_q unchanged; MOV B=0 → out 0, Z=1.
- Assert reset low mid-sequence with flags_q nonzero → flags_q=0 without clock edge; cond_ne=1.
- Build without ALU_SHIFT_EN: op 1000, A=0x0001, n=1 → alu_out 0, flag_write 0.

Source files
------------

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the 16-bit ALU: opcode encodings, flag bit positions
// and a helper that says which opcodes update the condition flags.
//
// Build option: ALU_SHIFT_EN -- when defined, opcodes 1000..1011 are the
// shift/rotate group; when undefined they behave as unused opcodes.
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_CMP  = 4'b0101;
    localparam logic [3:0] OP_MOV  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SLR  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_IDT  = 4'b1100;
    localparam logic [3:0] OP_OUT  = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // Flag vector layout: {V, C, Z, S}
    localparam int FLAG_S = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // Shifter sub-operation select, taken from op[1:0] of the shift group
    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SLR = 2'b01;
    localparam logic [1:0] SH_SRL = 2'b10;
    localparam logic [1:0] SH_SRA = 2'b11;

    function automatic logic op_writes_flags(input logic [3:0] op);
        logic w;
        w = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_CMP, OP_MOV:           w = 1'b1;
`ifdef ALU_SHIFT_EN
            OP_SLL, OP_SLR, OP_SRL, OP_SRA:   w = 1'b1;
`endif
            default:                          w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// ----------------------------------------------------------------------------
// alu_shifter
// Barrel shifter for the ALU shift group. Purely combinational.
//   i_data   [15:0]  value to shift
//   i_amt    [3:0]   shift amount 0..15 (0 passes data through)
//   i_sel    [1:0]   00 SLL, 01 rotate-left, 10 SRL, 11 SRA
//   o_result [15:0]  shifted value
//   o_carry          last bit shifted out (0 for rotate and for amount 0)
// ----------------------------------------------------------------------------
module alu_shifter
    import alu_pkg::*;
(
    input  logic [15:0] i_data,
    input  logic [3:0]  i_amt,
    input  logic [1:0]  i_sel,
    output logic [15:0] o_result,
    output logic        o_carry
);

    // One guard bit next to the data catches the last bit shifted out;
    // with a zero amount the guard stays 0, giving carry 0 for free.
    logic [16:0] w_left;
    logic [16:0] w_lright;
    logic [16:0] w_aright;
    logic [31:0] w_rot;

    assign w_left   = {1'b0, i_data} << i_amt;
    assign w_lright = {i_data, 1'b0} >> i_amt;
    assign w_aright = $signed({i_data, 1'b0}) >>> i_amt;
    // Rotate-left: shift a doubled copy and keep the upper half
    assign w_rot    = {i_data, i_data} << i_amt;

    always_comb begin
        o_result = i_data;
        o_carry  = 1'b0;
        case (i_sel)
            SH_SLL: begin
                o_result = w_left[15:0];
                o_carry  = w_left[16];
            end
            SH_SLR: begin
                o_result = w_rot[31:16];
                o_carry  = 1'b0;
            end
            SH_SRL: begin
                o_result = w_lright[16:1];
                o_carry  = w_lright[0];
            end
            default: begin
                o_result = w_aright[16:1];
                o_carry  = w_aright[0];
            end
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// ----------------------------------------------------------------------------
// alu_unit
// 16-bit arithmetic/logic/shift unit with a registered {V,C,Z,S} flag
// register and branch-condition decode. Result and next flags are
// combinational; only the flag register is clocked.
//
// Ports:
//   clock, reset       rising-edge clock, async active-low reset
//   op [3:0]           operation select
//   data_a, data_b     operands; shift amount is data_b[3:0]
//   flag_en            commit strobe for the flag register
//   alu_out [15:0]     combinational result
//   flag_out [3:0]     combinational next flags {V,C,Z,S}
//   flag_write         op updates the flags
//   flags_q [3:0]      registered flags
//   cond_eq/lt/le/ne   branch conditions decoded from flags_q
//
// Build option: ALU_SHIFT_EN enables the shift group (1000..1011); without
// it those opcodes read as unused and no shifter is built.
// ----------------------------------------------------------------------------
module alu_unit
    import alu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  op,
    input  logic [15:0] data_a,
    input  logic [15:0] data_b,
    input  logic        flag_en,
    output logic [15:0] alu_out,
    output logic [3:0]  flag_out,
    output logic        flag_write,
    output logic [3:0]  flags_q,
    output logic        cond_eq,
    output logic        cond_lt,
    output logic        cond_le,
    output logic        cond_ne
);

    logic [16:0] w_sum;
    logic [15:0] w_diff;
    logic        w_borrow;
    logic [15:0] w_res;
    logic        w_c;
    logic        w_v;
    logic        w_fw;
    logic [3:0]  r_flags;

`ifdef ALU_SHIFT_EN
    logic [15:0] w_sh_res;
    logic        w_sh_c;

    alu_shifter u_shifter (
        .i_data   (data_a),
        .i_amt    (data_b[3:0]),
        .i_sel    (op[1:0]),
        .o_result (w_sh_res),
        .o_carry  (w_sh_c)
    );
`endif

    assign w_sum    = {1'b0, data_a} + {1'b0, data_b};
    assign w_diff   = data_a - data_b;
    assign w_borrow = (data_a < data_b);
    assign w_fw     = op_writes_flags(op);

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (op)
            OP_ADD: begin
                w_res = w_sum[15:0];
                w_c   = w_sum[16];
                w_v   = (data_a[15] == data_b[15]) && (w_sum[15] != data_a[15]);
            end
            OP_SUB, OP_CMP: begin
                w_res = w_diff;
                w_c   = w_borrow;
                w_v   = (data_a[15] != data_b[15]) && (w_diff[15] != data_a[15]);
            end
            OP_AND:  w_res = data_a & data_b;
            OP_OR:   w_res = data_a | data_b;
            OP_XOR:  w_res = data_a ^ data_b;
            OP_MOV:  w_res = data_b;
`ifdef ALU_SHIFT_EN
            OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
                w_res = w_sh_res;
                w_c   = w_sh_c;
            end
`endif
            OP_IDT:  w_res = data_b;
            OP_OUT:  w_res = data_a;
            default: w_res = '0;
        endcase
    end

    assign alu_out    = w_res;
    assign flag_write = w_fw;

    always_comb begin
        flag_out = '0;
        if (w_fw) begin
            flag_out[FLAG_S] = w_res[15];
            flag_out[FLAG_Z] = (w_res == '0);
            flag_out[FLAG_C] = w_c;
            flag_out[FLAG_V] = w_v;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_flags <= '0;
        else if (flag_en && w_fw)
            r_flags <= flag_out;
    end

    assign flags_q = r_flags;
    assign cond_eq = r_flags[FLAG_Z];
    assign cond_lt = r_flags[FLAG_S] ^ r_flags[FLAG_V];
    assign cond_le = r_flags[FLAG_Z] | (r_flags[FLAG_S] ^ r_flags[FLAG_V]);
    assign cond_ne = ~r_flags[FLAG_Z];

endmodule

// File: tb/tb_alu_unit.sv
module tb_alu_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic [15:0] data_a, data_b;
    logic        flag_en;
    logic [15:0] alu_out;
    logic [3:0]  flag_out;
    logic        flag_write;
    logic [3:0]  flags_q;
    logic        cond_eq, cond_lt, cond_le, cond_ne;

    int total = 0;
    int bad   = 0;

    alu_unit dut (
        .clock      (clock),
        .reset      (reset),
        .op         (op),
        .data_a     (data_a),
        .data_b     (data_b),
        .flag_en    (flag_en),
        .alu_out    (alu_out),
        .flag_out   (flag_out),
        .flag_write (flag_write),
        .flags_q    (flags_q),
        .cond_eq    (cond_eq),
        .cond_lt    (cond_lt),
        .cond_le    (cond_le),
        .cond_ne    (cond_ne)
    );

    always #5 clock = ~clock;

    // flags layout {V,C,Z,S}
    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        fen;
        logic [15:0] exp_out;
        logic        exp_fw;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    logic [3:0] model_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_conds(input string name);
        chk({name, " flags_q"}, {28'd0, flags_q}, {28'd0, model_q});
        chk({name, " cond_eq"}, {31'd0, cond_eq}, {31'd0, model_q[1]});
        chk({name, " cond_lt"}, {31'd0, cond_lt}, {31'd0, model_q[0] ^ model_q[3]});
        chk({name, " cond_le"}, {31'd0, cond_le}, {31'd0, model_q[1] | (model_q[0] ^ model_q[3])});
        chk({name, " cond_ne"}, {31'd0, cond_ne}, {31'd0, ~model_q[1]});
    endtask

    task automatic add_vec(input string n, input logic [3:0] o, input logic [15:0] a,
                           input logic [15:0] b, input logic fen, input logic [15:0] eo,
                           input logic efw, input logic [3:0] ef);
        vec_t v;
        v.name = n; v.op = o; v.a = a; v.b = b; v.fen = fen;
        v.exp_out = eo; v.exp_fw = efw; v.exp_flags = ef;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clock);
        op = v.op; data_a = v.a; data_b = v.b; flag_en = v.fen;
        sb.push_back(v);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.name, " alu_out"},    {16'd0, alu_out},    {16'd0, e.exp_out});
            chk({e.name, " flag_write"}, {31'd0, flag_write}, {31'd0, e.exp_fw});
            chk({e.name, " flag_out"},   {28'd0, flag_out},   {28'd0, e.exp_flags});
            if (e.fen && e.exp_fw) model_q = e.exp_flags;
        end
        @(posedge clock);
        #1;
        check_conds(v.name);
    endtask

    initial begin
        reset = 1'b0; op = 4'h0; data_a = '0; data_b = '0; flag_en = 1'b0;
        model_q = 4'h0;

        //       name        op     A        B        fen  out      fw   {V,C,Z,S}
        add_vec("add_ovf",  4'h0, 16'h7FFF, 16'h0001, 1, 16'h8000, 1, 4'b1001);
        add_vec("sub_neg",  4'h1, 16'h0003, 16'h0005, 1, 16'hFFFE, 1, 4'b0101);
        add_vec("cmp_eq",   4'h5, 16'h1234, 16'h1234, 1, 16'h0000, 1, 4'b0010);
        add_vec("add_cz",   4'h0, 16'hFFFF, 16'h0001, 1, 16'h0000, 1, 4'b0110);
        add_vec("add_hold", 4'h0, 16'h0001, 16'h0001, 0, 16'h0002, 1, 4'b0000);
        add_vec("and",      4'h2, 16'hF0F0, 16'h0FF0, 1, 16'h00F0, 1, 4'b0000);
        add_vec("or",       4'h3, 16'h8000, 16'h0001, 1, 16'h8001, 1, 4'b0001);
        add_vec("xor_z",    4'h4, 16'hAAAA, 16'hAAAA, 1, 16'h0000, 1, 4'b0010);
        add_vec("sub_ovf",  4'h1, 16'h8000, 16'h0001, 1, 16'h7FFF, 1, 4'b1000);
        add_vec("mov_z",    4'h6, 16'h5555, 16'h0000, 1, 16'h0000, 1, 4'b0010);
        add_vec("sub_lt",   4'h1, 16'h0003, 16'h0005, 1, 16'hFFFE, 1, 4'b0101);
        add_vec("idt",      4'hC, 16'h1234, 16'h5678, 1, 16'h5678, 0, 4'b0000);
        add_vec("out",      4'hD, 16'h1234, 16'h5678, 1, 16'h1234, 0, 4'b0000);
        add_vec("halt",     4'hF, 16'h1234, 16'h5678, 1, 16'h0000, 0, 4'b0000);
        add_vec("unused7",  4'h7, 16'h1234, 16'h5678, 1, 16'h0000, 0, 4'b0000);
        add_vec("unusedE",  4'hE, 16'h1234, 16'h5678, 1, 16'h0000, 0, 4'b0000);
`ifdef ALU_SHIFT_EN
        add_vec("sll_c",    4'h8, 16'h8001, 16'h00F1, 1, 16'h0002, 1, 4'b0100);
        add_vec("sra_15",   4'hB, 16'h8000, 16'h000F, 1, 16'hFFFF, 1, 4'b0001);
        add_vec("slr_4",    4'h9, 16'h8001, 16'h0004, 1, 16'h0018, 1, 4'b0000);
        add_vec("sll_n0",   4'h8, 16'h1234, 16'h0010, 1, 16'h1234, 1, 4'b0000);
        add_vec("srl_c",    4'hA, 16'h0003, 16'h0001, 1, 16'h0001, 1, 4'b0100);
        add_vec("srl_n0",   4'hA, 16'h8001, 16'h0000, 1, 16'h8001, 1, 4'b0001);
`else
        add_vec("sll_off",  4'h8, 16'h0001, 16'h0001, 1, 16'h0000, 0, 4'b0000);
        add_vec("sra_off",  4'hB, 16'h8000, 16'h000F, 1, 16'h0000, 0, 4'b0000);
`endif

        // Reset state
        #2;
        check_conds("reset");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check_conds("post_release");

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Mid-sequence async reset with nonzero flags, no clock edge involved
        begin
            vec_t v;
            v.name = "pre_rst"; v.op = 4'h1; v.a = 16'h0003; v.b = 16'h0005; v.fen = 1'b1;
            v.exp_out = 16'hFFFE; v.exp_fw = 1'b1; v.exp_flags = 4'b0101;
            apply(v);
        end
        #2;
        reset = 1'b0;
        #1;
        model_q = 4'h0;
        check_conds("async_rst");
        // Release with flag_en low: release edge must not load anything
        @(negedge clock);
        op = 4'h0; data_a = 16'h7FFF; data_b = 16'h0001; flag_en = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        check_conds("release_hold");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
